// File: rtl/branch_pred_if.sv
// Fetch/EX signal bundle between the pipeline and the branch prediction controller.
// stat_* carry counters only when BRANCH_PRED_STATS_EN is defined, otherwise they read zero.
interface branch_pred_if;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_target;
    logic        pred_taken;
    logic [31:0] pred_pc;
    logic        fetch_stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_target;
    logic [2:0]  ex_funct3;
    logic        brun;
    logic        brlt;
    logic        breq;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        order_err;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    modport master (
        output if_valid, if_pc, if_target, ex_valid, ex_pc, ex_target, ex_funct3, brlt, breq,
        input  pred_taken, pred_pc, fetch_stall, brun, flush, redirect_pc, order_err,
               stat_branches, stat_mispredicts
    );

    modport slave (
        input  if_valid, if_pc, if_target, ex_valid, ex_pc, ex_target, ex_funct3, brlt, breq,
        output pred_taken, pred_pc, fetch_stall, brun, flush, redirect_pc, order_err,
               stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_pred_ctrl.sv
// Branch predictor (2-bit BHT + in-order prediction FIFO) and EX-stage resolution/flush logic.
// Optional feature macro: BRANCH_PRED_STATS_EN enables the branch/mispredict statistic counters.
module branch_pred_ctrl #(
    parameter int unsigned BHT_IDX_BITS = 6,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [1:0]  CTR_RESET    = 2'b01
) (
    input logic         clk,
    input logic         rst_n,
    branch_pred_if.slave bus
);
    localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW    = PtrW + 1;
    localparam int unsigned BhtSize = 1 << BHT_IDX_BITS;

    typedef struct packed {
        logic [31:0]             pc;
        logic                    pred;
        logic [BHT_IDX_BITS-1:0] idx;
    } entry_t;

    entry_t          fifo_q [FIFO_DEPTH];
    logic [1:0]      bht_q  [BhtSize];
    logic [PtrW-1:0] rd_q, wr_q;
    logic [CntW-1:0] cnt_q;
    logic            order_err_q;

    logic [BHT_IDX_BITS-1:0] if_idx;
    logic                    full, empty, push, pop;
    logic                    actual, head_pred, order_set;
    logic [1:0]              ctr_cur, ctr_next;
    entry_t                  head;

    always_comb begin
        if_idx          = bus.if_pc[BHT_IDX_BITS+1:2];
        full            = (cnt_q == CntW'(FIFO_DEPTH));
        empty           = (cnt_q == '0);
        head            = fifo_q[rd_q];
        // Fetch reads the pre-write counter even if EX trains the same entry this cycle.
        bus.pred_taken  = bus.if_valid & bht_q[if_idx][1];
        bus.pred_pc     = bus.pred_taken ? bus.if_target : bus.if_pc + 32'd4;
        bus.fetch_stall = full & ~bus.ex_valid;
        bus.brun        = bus.ex_funct3[1];

        case (bus.ex_funct3)
            3'b000:         actual = bus.breq;
            3'b001:         actual = ~bus.breq;
            3'b100, 3'b110: actual = bus.brlt;
            3'b101, 3'b111: actual = ~bus.brlt;
            default:        actual = 1'b0;
        endcase

        head_pred       = ~empty & head.pred;
        bus.flush       = bus.ex_valid & (actual != head_pred);
        bus.redirect_pc = '0;
        if (bus.flush) begin
            bus.redirect_pc = actual ? bus.ex_target : bus.ex_pc + 32'd4;
        end

        push      = bus.if_valid & ~bus.fetch_stall & ~bus.flush;
        pop       = bus.ex_valid & ~empty;
        order_set = bus.ex_valid & (empty | (head.pc != bus.ex_pc));

        ctr_cur  = bht_q[head.idx];
        ctr_next = ctr_cur;
        if (actual) begin
            if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'b01;
        end else begin
            if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'b01;
        end
        bus.order_err = order_err_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q        <= '0;
            wr_q        <= '0;
            cnt_q       <= '0;
            order_err_q <= 1'b0;
            for (int i = 0; i < BhtSize; i++) begin
                bht_q[i] <= CTR_RESET;
            end
        end else begin
            if (bus.flush) begin
                rd_q  <= '0;
                wr_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push) begin
                    fifo_q[wr_q] <= '{pc: bus.if_pc, pred: bus.pred_taken, idx: if_idx};
                    wr_q         <= wr_q + PtrW'(1);
                end
                if (pop) begin
                    rd_q <= rd_q + PtrW'(1);
                end
                case ({push, pop})
                    2'b10:   cnt_q <= cnt_q + CntW'(1);
                    2'b01:   cnt_q <= cnt_q - CntW'(1);
                    default: cnt_q <= cnt_q;
                endcase
            end
            // Training needs a real head entry; an orphan EX branch has no index to train.
            if (pop) begin
                bht_q[head.idx] <= ctr_next;
            end
            if (order_set) begin
                order_err_q <= 1'b1;
            end
        end
    end

`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] stat_br_q, stat_mis_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            if (bus.ex_valid) stat_br_q  <= stat_br_q + 32'd1;
            if (bus.flush)    stat_mis_q <= stat_mis_q + 32'd1;
        end
    end

    assign bus.stat_branches    = stat_br_q;
    assign bus.stat_mispredicts = stat_mis_q;
`else
    assign bus.stat_branches    = 32'd0;
    assign bus.stat_mispredicts = 32'd0;
`endif
endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Scoreboard bench for branch_pred_ctrl: stimulus queues expected responses, a negedge monitor
// pops and compares them whenever fetch or EX is active.
module tb_branch_pred_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    branch_pred_if bus ();

    branch_pred_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        pt;
        logic [31:0] ppc;
        logic        stall;
    } fexp_t;

    typedef struct {
        logic        brun;
        logic        flush;
        logic [31:0] rpc;
    } eexp_t;

    fexp_t fq[$];
    eexp_t eq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.if_valid) begin
                if (fq.size() == 0) begin
                    check("fetch_unexpected", 32'd1, 32'd0);
                end else begin
                    fexp_t f;
                    f = fq.pop_front();
                    check("pred_taken", bus.pred_taken, f.pt);
                    check("pred_pc", bus.pred_pc, f.ppc);
                    check("fetch_stall", bus.fetch_stall, f.stall);
                end
            end
            if (bus.ex_valid) begin
                if (eq.size() == 0) begin
                    check("ex_unexpected", 32'd1, 32'd0);
                end else begin
                    eexp_t e;
                    e = eq.pop_front();
                    check("brun", bus.brun, e.brun);
                    check("flush", bus.flush, e.flush);
                    check("redirect_pc", bus.redirect_pc, e.rpc);
                end
            end
        end
    end

    task automatic idle();
        bus.if_valid  = 1'b0;
        bus.if_pc     = '0;
        bus.if_target = '0;
        bus.ex_valid  = 1'b0;
        bus.ex_pc     = '0;
        bus.ex_target = '0;
        bus.ex_funct3 = '0;
        bus.brlt      = 1'b0;
        bus.breq      = 1'b0;
    endtask

    // One cycle: optional fetch with expected prediction, optional EX with expected resolution.
    task automatic step(input logic iv, input logic [31:0] ipc, input logic [31:0] itgt,
                        input logic fpt, input logic [31:0] fppc, input logic fst,
                        input logic ev, input logic [31:0] epc, input logic [31:0] etgt,
                        input logic [2:0] f3, input logic lt, input logic eqin,
                        input logic xbrun, input logic xfl, input logic [31:0] xrpc);
        idle();
        bus.if_valid  = iv;
        bus.if_pc     = ipc;
        bus.if_target = itgt;
        bus.ex_valid  = ev;
        bus.ex_pc     = epc;
        bus.ex_target = etgt;
        bus.ex_funct3 = f3;
        bus.brlt      = lt;
        bus.breq      = eqin;
        if (iv) fq.push_back('{pt: fpt, ppc: fppc, stall: fst});
        if (ev) eq.push_back('{brun: xbrun, flush: xfl, rpc: xrpc});
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic fetch(input logic [31:0] pc, input logic [31:0] tgt, input logic pt,
                         input logic stall);
        step(1'b1, pc, tgt, pt, pt ? tgt : pc + 32'd4, stall,
             1'b0, '0, '0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt, input logic [2:0] f3,
                           input logic lt, input logic eqin, input logic xfl,
                           input logic [31:0] xrpc);
        step(1'b0, '0, '0, 1'b0, '0, 1'b0,
             1'b1, pc, tgt, f3, lt, eqin, f3[1], xfl, xrpc);
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_pred_taken", bus.pred_taken, 32'd0);
        check("rst_fetch_stall", bus.fetch_stall, 32'd0);
        check("rst_flush", bus.flush, 32'd0);
        check("rst_redirect", bus.redirect_pc, 32'd0);
        check("rst_order_err", bus.order_err, 32'd0);
        check("rst_stat_br", bus.stat_branches, 32'd0);
        check("rst_stat_mis", bus.stat_mispredicts, 32'd0);
        @(posedge clk);
        #1;

        // Counter for pc 0x100 walks 01 -> 10 -> 11 -> 11 (saturated) -> 10.
        fetch(32'h100, 32'h180, 1'b0, 1'b0);
        resolve(32'h100, 32'h180, 3'b000, 1'b0, 1'b1, 1'b1, 32'h180);
        fetch(32'h100, 32'h180, 1'b1, 1'b0);
        resolve(32'h100, 32'h180, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0);
        fetch(32'h100, 32'h180, 1'b1, 1'b0);
        resolve(32'h100, 32'h180, 3'b000, 1'b0, 1'b1, 1'b0, 32'h0);
        fetch(32'h100, 32'h180, 1'b1, 1'b0);
        resolve(32'h100, 32'h180, 3'b110, 1'b1, 1'b0, 1'b0, 32'h0);   // BLTU taken
        fetch(32'h100, 32'h180, 1'b1, 1'b0);
        resolve(32'h100, 32'h180, 3'b101, 1'b1, 1'b0, 1'b1, 32'h104); // BGE not taken

        // Fill the FIFO, then stall, push+pop at full, and flush dropping the push.
        fetch(32'h004, 32'h044, 1'b0, 1'b0);
        fetch(32'h008, 32'h048, 1'b0, 1'b0);
        fetch(32'h00c, 32'h04c, 1'b0, 1'b0);
        fetch(32'h010, 32'h050, 1'b0, 1'b0);
        fetch(32'h014, 32'h054, 1'b0, 1'b1);
        step(1'b1, 32'h014, 32'h054, 1'b0, 32'h018, 1'b0,
             1'b1, 32'h004, 32'h044, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        fetch(32'h018, 32'h058, 1'b0, 1'b1);
        step(1'b1, 32'h018, 32'h058, 1'b0, 32'h01c, 1'b0,
             1'b1, 32'h008, 32'h048, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 32'h048);
        fetch(32'h01c, 32'h05c, 1'b0, 1'b0);
        resolve(32'h01c, 32'h05c, 3'b010, 1'b0, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        check("order_err_clean", bus.order_err, 32'd0);
        @(posedge clk);
        #1;

        // Orphan EX branch: treated as predicted not-taken, sets sticky order_err.
        resolve(32'h500, 32'h600, 3'b000, 1'b0, 1'b1, 1'b1, 32'h600);
        @(negedge clk);
        check("order_err_set", bus.order_err, 32'd1);
        @(posedge clk);
        #1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("order_err_sticky", bus.order_err, 32'd1);
`ifdef BRANCH_PRED_STATS_EN
        check("stat_branches", bus.stat_branches, 32'd9);
        check("stat_mispredicts", bus.stat_mispredicts, 32'd4);
`else
        check("stat_branches", bus.stat_branches, 32'd0);
        check("stat_mispredicts", bus.stat_mispredicts, 32'd0);
`endif

        // Reset mid-operation clears order_err and the FIFO contents.
        fetch(32'h100, 32'h180, 1'b1, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_order_err", bus.order_err, 32'd0);
        @(posedge clk);
        #1;
        fetch(32'h100, 32'h180, 1'b0, 1'b0);

        for (int i = 0; i < 20 && (fq.size() != 0 || eq.size() != 0); i++) @(posedge clk);
        check("fetch_queue_drained", fq.size(), 32'd0);
        check("ex_queue_drained", eq.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
